// File: rtl/md5_job_arbiter_if.sv
// Handshake bundle between the MD5 job arbiter, its requesters and the shared core.
// Optional match ports are present only when MD5_ARB_MATCH_EN is defined.
interface md5_job_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ*128-1:0] req_msg;
    logic [N_REQ*8-1:0]   req_width;
    logic [N_REQ-1:0]     req_grant;
    logic [127:0]         core_msg;
    logic [7:0]           core_width;
    logic                 core_valid;
    logic                 core_ready;
    logic [127:0]         core_out;
    logic                 core_out_valid;
    logic [N_REQ-1:0]     rsp_valid;
    logic [127:0]         rsp_digest;
    logic [ID_W-1:0]      rsp_id;
    logic                 busy;
    logic                 err_orphan;
`ifdef MD5_ARB_MATCH_EN
    logic [127:0]         target;
    logic                 match;
    logic [ID_W-1:0]      match_id;

    modport master (
        input  req_valid, req_msg, req_width, core_ready, core_out, core_out_valid, target,
        output req_grant, core_msg, core_width, core_valid, rsp_valid, rsp_digest, rsp_id,
               busy, err_orphan, match, match_id
    );
    modport slave (
        output req_valid, req_msg, req_width, core_ready, core_out, core_out_valid, target,
        input  req_grant, core_msg, core_width, core_valid, rsp_valid, rsp_digest, rsp_id,
               busy, err_orphan, match, match_id
    );
`else
    modport master (
        input  req_valid, req_msg, req_width, core_ready, core_out, core_out_valid,
        output req_grant, core_msg, core_width, core_valid, rsp_valid, rsp_digest, rsp_id,
               busy, err_orphan
    );
    modport slave (
        output req_valid, req_msg, req_width, core_ready, core_out, core_out_valid,
        input  req_grant, core_msg, core_width, core_valid, rsp_valid, rsp_digest, rsp_id,
               busy, err_orphan
    );
`endif
endinterface

// File: rtl/md5_job_arbiter.sv
// Round-robin sharing of one MD5 core between N_REQ requesters, with an owner-tag FIFO
// routing digests back. MD5_ARB_MATCH_EN adds sticky target matching that halts issue.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for core_ready, a request and FIFO space
// ST_SETTLE  | counting SETTLE_CYC cycles after an issue, core_ready ignored
module md5_job_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ID_W       = 2,
    parameter int TAG_DEPTH  = 4,
    parameter int SETTLE_CYC = 2
) (
    input logic             clk,
    input logic             reset,
    md5_job_arbiter_if.master bus
);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SETTLE = 1'b1;

    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    logic [0:0]       state;
    logic [SET_W-1:0] settle_cnt;
    logic [ID_W-1:0]  rr_ptr;

    logic [ID_W-1:0]  tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] tag_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic [ID_W-1:0]  head_id;

    logic             ov_q;
    logic             ov_rise;
    logic             push;
    logic             pop;
    logic             match_hold;

    logic             win_found;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  cand;
    logic [127:0]     win_msg;
    logic [7:0]       win_wid;

    assign fifo_full  = (tag_cnt == CNT_W'(TAG_DEPTH));
    assign fifo_empty = (tag_cnt == '0);
    assign head_id    = tag_mem[rd_ptr];
    assign bus.busy   = !fifo_empty;

`ifdef MD5_ARB_MATCH_EN
    assign match_hold = bus.match;
`else
    assign match_hold = 1'b0;
`endif

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        win_msg = '0;
        win_wid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                win_msg = bus.req_msg[128*i +: 128];
                win_wid = bus.req_width[8*i +: 8];
            end
        end
    end

    assign push    = (state == ST_IDLE) && bus.core_ready && win_found && !fifo_full && !match_hold;
    assign ov_rise = bus.core_out_valid && !ov_q;
    assign pop     = ov_rise && !fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            settle_cnt     <= '0;
            rr_ptr         <= ID_W'(N_REQ - 1);
            bus.core_msg   <= '0;
            bus.core_width <= '0;
            bus.core_valid <= 1'b0;
            bus.req_grant  <= '0;
        end else begin
            bus.core_valid <= 1'b0;
            bus.req_grant  <= '0;
            case (state)
                ST_IDLE: begin
                    if (push) begin
                        bus.core_msg   <= win_msg;
                        bus.core_width <= win_wid;
                        bus.core_valid <= 1'b1;
                        bus.req_grant  <= N_REQ'(1) << win_id;
                        rr_ptr         <= win_id;
                        settle_cnt     <= SET_W'(SETTLE_CYC - 1);
                        state          <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) state <= ST_IDLE;
                    else                  settle_cnt <= settle_cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) tag_mem[i] <= '0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= win_id;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   tag_cnt <= tag_cnt + 1'b1;
                2'b01:   tag_cnt <= tag_cnt - 1'b1;
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    // A held core_out_valid level yields one response; an edge with no owner is an orphan.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ov_q           <= 1'b0;
            bus.rsp_valid  <= '0;
            bus.rsp_id     <= '0;
            bus.rsp_digest <= '0;
            bus.err_orphan <= 1'b0;
`ifdef MD5_ARB_MATCH_EN
            bus.match      <= 1'b0;
            bus.match_id   <= '0;
`endif
        end else begin
            ov_q           <= bus.core_out_valid;
            bus.rsp_valid  <= '0;
            bus.rsp_id     <= '0;
            bus.rsp_digest <= '0;
            if (pop) begin
                bus.rsp_valid  <= N_REQ'(1) << head_id;
                bus.rsp_id     <= head_id;
                bus.rsp_digest <= bus.core_out;
`ifdef MD5_ARB_MATCH_EN
                if (bus.core_out == bus.target) begin
                    bus.match    <= 1'b1;
                    bus.match_id <= head_id;
                end
`endif
            end
            if (ov_rise && fifo_empty) bus.err_orphan <= 1'b1;
        end
    end
endmodule

// File: tb/tb_md5_job_arbiter.sv
// Randomized bench for md5_job_arbiter: a queue-based reference model predicts every
// output each cycle; a stand-in core returns pseudo-digests in issue order.
module tb_md5_job_arbiter;
    localparam int N_REQ      = 4;
    localparam int ID_W       = 2;
    localparam int TAG_DEPTH  = 4;
    localparam int SETTLE_CYC = 2;
    localparam logic [127:0] MSG_A = 128'h6161_6161_6161_6161;
    localparam logic [127:0] DIG_A = 128'h82cf1a5e_9d0c4b77_e2f03a61_5c9d3fb2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    md5_job_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus();

    md5_job_arbiter #(
        .N_REQ(N_REQ), .ID_W(ID_W), .TAG_DEPTH(TAG_DEPTH), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    logic [N_REQ-1:0] rv = '0;
    logic [127:0]     msg [N_REQ];
    logic [7:0]       wid [N_REQ];
    logic             cr  = 1'b0;
    logic             cov = 1'b0;
    logic [127:0]     co  = '0;

    assign bus.req_valid      = rv;
    assign bus.core_ready     = cr;
    assign bus.core_out       = co;
    assign bus.core_out_valid = cov;
    for (genvar g = 0; g < N_REQ; g++) begin : g_pack
        assign bus.req_msg[128*g +: 128] = msg[g];
        assign bus.req_width[8*g +: 8]   = wid[g];
    end
`ifdef MD5_ARB_MATCH_EN
    logic [127:0] tgt = '0;
    assign bus.target = tgt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] core_digest(logic [127:0] m);
        if (m == MSG_A) return DIG_A;
        return {m[63:0] ^ 64'h9e3779b97f4a7c15, m[127:64] + 64'h0123456789abcdef};
    endfunction

    // Reference model: spec rules applied per clock edge with a queue of owner IDs.
    bit               m_rst = 1'b1;
    int               m_ptr, m_settle, m_n, m_w, m_idx, m_id;
    int               m_tags [$];
    bit               m_ov, m_err, m_match, m_rise, m_can;
    int               m_mid;
    logic [N_REQ-1:0] e_grant, e_rv;
    logic             e_cv;
    logic [127:0]     e_cmsg, e_rdig;
    logic [7:0]       e_cwid;
    int               e_rid;

    always @(posedge clk) begin
        if (reset) begin
            m_rst = 1'b1; m_ptr = N_REQ - 1; m_settle = 0; m_tags.delete();
            m_ov = 1'b0; m_err = 1'b0; m_match = 1'b0; m_mid = 0;
            e_grant = '0; e_cv = 1'b0; e_cmsg = '0; e_cwid = '0; e_rv = '0; e_rid = 0; e_rdig = '0;
        end else begin
            m_rst  = 1'b0;
            m_n    = m_tags.size();
            m_rise = cov && !m_ov;
            m_ov   = cov;
            m_can  = (m_settle == 0) && cr && (rv != '0) && (m_n < TAG_DEPTH) && !m_match;
            e_grant = '0; e_cv = 1'b0; e_rv = '0; e_rid = 0; e_rdig = '0;
            if (m_settle > 0) m_settle--;
            if (m_rise && m_n == 0) m_err = 1'b1;
            if (m_rise && m_n > 0) begin
                m_id   = m_tags.pop_front();
                e_rv   = N_REQ'(1) << m_id;
                e_rid  = m_id;
                e_rdig = co;
`ifdef MD5_ARB_MATCH_EN
                if (co == tgt) begin m_match = 1'b1; m_mid = m_id; end
`endif
            end
            if (m_can) begin
                m_w = -1;
                for (int k = 1; k <= N_REQ; k++) begin
                    m_idx = (m_ptr + k) % N_REQ;
                    if (m_w < 0 && rv[m_idx]) m_w = m_idx;
                end
                m_tags.push_back(m_w);
                m_ptr    = m_w;
                m_settle = SETTLE_CYC;
                e_grant  = N_REQ'(1) << m_w;
                e_cv     = 1'b1;
                e_cmsg   = msg[m_w];
                e_cwid   = wid[m_w];
            end
        end
    end

    logic [127:0] core_q [$];
    bit           core_auto = 1'b0;
    int           req_mode  = 0;   // 0 one-shot, 1 continuous, 2 random
    int           n_grant   = 0;
    int           glog [$];

    task automatic new_msg(int i);
        msg[i] = {$urandom, $urandom, $urandom, $urandom};
        wid[i] = 8'($urandom_range(1, 128));
    endtask

    task automatic tick();
        @(negedge clk);
        if (!m_rst) begin
            chk("grant", 128'(bus.req_grant), 128'(e_grant));
            chk("core_valid", 128'(bus.core_valid), 128'(e_cv));
            chk("core_msg", bus.core_msg, e_cmsg);
            chk("core_width", 128'(bus.core_width), 128'(e_cwid));
            chk("rsp_valid", 128'(bus.rsp_valid), 128'(e_rv));
            if (e_rv != '0) begin
                chk("rsp_id", 128'(bus.rsp_id), 128'(e_rid));
                chk("rsp_digest", bus.rsp_digest, e_rdig);
            end
            chk("busy", 128'(bus.busy), 128'(m_tags.size() != 0));
            chk("err_orphan", 128'(bus.err_orphan), 128'(m_err));
`ifdef MD5_ARB_MATCH_EN
            chk("match", 128'(bus.match), 128'(m_match));
            if (m_match) chk("match_id", 128'(bus.match_id), 128'(m_mid));
`endif
        end
        if (bus.core_valid) core_q.push_back(core_digest(bus.core_msg));
        if (core_auto) begin
            if (cov) begin
                if ($urandom_range(0, 1) == 1) cov = 1'b0;
            end else if (core_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                cov = 1'b1;
                co  = core_q.pop_front();
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.req_grant[i]) begin
                n_grant++;
                glog.push_back(i);
                case (req_mode)
                    0: rv[i] = 1'b0;
                    1: new_msg(i);
                    default: begin new_msg(i); rv[i] = ($urandom_range(0, 1) == 1); end
                endcase
            end else if (req_mode == 2) begin
                if (!rv[i] && $urandom_range(0, 3) == 0) begin new_msg(i); rv[i] = 1'b1; end
                else if (rv[i] && $urandom_range(0, 15) == 0) rv[i] = 1'b0;
            end
        end
    endtask

    task automatic do_reset(bit check_zero);
        #2 reset = 1'b1;
        if (check_zero) begin
            #1;
            chk("rst_grant", 128'(bus.req_grant), 128'(0));
            chk("rst_core_valid", 128'(bus.core_valid), 128'(0));
            chk("rst_core_msg", bus.core_msg, 128'(0));
            chk("rst_core_width", 128'(bus.core_width), 128'(0));
            chk("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
            chk("rst_rsp_id", 128'(bus.rsp_id), 128'(0));
            chk("rst_rsp_digest", bus.rsp_digest, 128'(0));
            chk("rst_busy", 128'(bus.busy), 128'(0));
            chk("rst_err_orphan", 128'(bus.err_orphan), 128'(0));
        end
        rv = '0; cov = 1'b0; co = '0; cr = 1'b0;
        core_q.delete(); glog.delete(); n_grant = 0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic wait_grant(string tag, int bound, output int cyc);
        cyc = 0;
        do begin tick(); cyc++; end while (bus.req_grant == '0 && cyc < bound);
        chk(tag, 128'(bus.req_grant != '0), 128'(1));
    endtask

    task automatic wait_rsp(string tag, int bound, output int cyc);
        cyc = 0;
        do begin tick(); cyc++; end while (bus.rsp_valid == '0 && cyc < bound);
        chk(tag, 128'(bus.rsp_valid != '0), 128'(1));
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < N_REQ; i++) new_msg(i);
        do_reset(1'b1);

        // single requester, known digest
        msg[2] = MSG_A; wid[2] = 8'd64;
        req_mode = 0; core_auto = 1'b1; cr = 1'b1; rv = 4'b0100;
        wait_grant("single_grant_seen", 10, cyc);
        chk("single_latency", 128'(cyc), 128'(1));
        chk("single_grant", 128'(bus.req_grant), 128'(4'b0100));
        chk("single_core_valid", 128'(bus.core_valid), 128'(1));
        chk("single_core_msg", bus.core_msg, MSG_A);
        wait_rsp("single_rsp_seen", 40, cyc);
        chk("single_rsp_valid", 128'(bus.rsp_valid), 128'(4'b0100));
        chk("single_rsp_id", 128'(bus.rsp_id), 128'(2));
        chk("single_rsp_digest", bus.rsp_digest, DIG_A);

        // round-robin with all four requesting
        do_reset(1'b0);
        for (int i = 0; i < N_REQ; i++) new_msg(i);
        req_mode = 1; core_auto = 1'b1; cr = 1'b1; rv = 4'hF;
        repeat (60) tick();
        chk("rr_enough_grants", 128'(glog.size() >= 6), 128'(1));
        for (int i = 0; i < 6 && i < glog.size(); i++)
            chk("rr_order", 128'(glog[i]), 128'(i % N_REQ));

        // full FIFO: core withholds outputs
        do_reset(1'b0);
        req_mode = 1; core_auto = 1'b0; cr = 1'b1; rv = 4'hF;
        repeat (40) tick();
        chk("full_grants", 128'(n_grant), 128'(TAG_DEPTH));
        chk("full_busy", 128'(bus.busy), 128'(1));
        cov = 1'b1; co = core_q.pop_front();
        tick();
        cov = 1'b0;
        repeat (15) tick();
        chk("full_one_more", 128'(n_grant), 128'(TAG_DEPTH + 1));

        // push and pop on the same edge
        do_reset(1'b0);
        req_mode = 0; core_auto = 1'b0; cr = 1'b1; rv = 4'b0001;
        wait_grant("pp_first_grant", 10, cyc);
        repeat (3) tick();
        rv = 4'b1000; cov = 1'b1; co = core_q.pop_front();
        tick();
        chk("pp_grant", 128'(bus.req_grant), 128'(4'b1000));
        chk("pp_rsp_valid", 128'(bus.rsp_valid), 128'(4'b0001));
        chk("pp_busy", 128'(bus.busy), 128'(1));
        cov = 1'b0;
        repeat (3) tick();
        cov = 1'b1; co = core_q.pop_front();
        tick();
        chk("pp_rsp_id2", 128'(bus.rsp_id), 128'(3));
        cov = 1'b0;
        tick();
        chk("pp_drained", 128'(bus.busy), 128'(0));

        // reset with two in flight, then a stale digest
        do_reset(1'b0);
        req_mode = 0; core_auto = 1'b0; cr = 1'b1; rv = 4'b0011;
        repeat (8) tick();
        chk("orph_two_grants", 128'(n_grant), 128'(2));
        chk("orph_busy", 128'(bus.busy), 128'(1));
        do_reset(1'b1);
        cov = 1'b1; co = {$urandom, $urandom, $urandom, $urandom};
        tick();
        chk("orph_err", 128'(bus.err_orphan), 128'(1));
        chk("orph_no_rsp", 128'(bus.rsp_valid), 128'(0));
        cov = 1'b0;
        tick();

        // random soak
        do_reset(1'b0);
        req_mode = 2; core_auto = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            cr = ($urandom_range(0, 9) < 7);
            tick();
        end
        req_mode = 0; rv = '0; cr = 1'b1;
        repeat (100) tick();
        chk("soak_drained", 128'(bus.busy), 128'(0));
        chk("soak_no_orphan", 128'(bus.err_orphan), 128'(0));

`ifdef MD5_ARB_MATCH_EN
        do_reset(1'b0);
        for (int i = 0; i < N_REQ; i++) new_msg(i);
        tgt = core_digest(msg[1]);
        req_mode = 1; core_auto = 1'b1; cr = 1'b1; rv = 4'hF;
        cyc = 0;
        do begin tick(); cyc++; end while (!bus.match && cyc < 200);
        chk("match_seen", 128'(bus.match), 128'(1));
        chk("match_rsp_valid", 128'(bus.rsp_valid), 128'(4'b0010));
        chk("match_id_val", 128'(bus.match_id), 128'(1));
        n_grant = 0;
        repeat (60) tick();
        chk("match_no_grant", 128'(n_grant), 128'(0));
        chk("match_sticky", 128'(bus.match), 128'(1));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
